// File: rtl/sync_frame_tx_pkg.sv
// Shared definitions for the 1010 sync-frame transmitter and its companion detector.
// Keeps the preamble defaults in one place so both ends stay in step.
package sync_frame_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_t;

    localparam int                       DEFAULT_PRE_W    = 4;
    localparam logic [DEFAULT_PRE_W-1:0] DEFAULT_PREAMBLE = 4'b1010;

    // Counter width that covers the longest state, never narrower than 1 bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_frame_tx_piso_shift.sv
// Parallel-load, shift-left register; the payload leaves MSB first through msb.
module piso_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              msb
);

    logic [DATA_W-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= sr << 1;
        end
    end

    assign msb = sr[DATA_W-1];

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: preamble, MSB-first payload, then idle gap bits.
// Outputs are registered from the next state so the first preamble bit follows the accept edge.
module sync_frame_tx
    import sync_frame_tx_pkg::*;
#(
    parameter int               DATA_W     = 8,
    parameter int               PRE_W      = DEFAULT_PRE_W,
    parameter logic [PRE_W-1:0] PREAMBLE   = PRE_W'(DEFAULT_PREAMBLE),
    parameter int               GAP_CYCLES = 2,
    parameter logic             IDLE_BIT   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out,
    output logic              out_valid,
    output logic              frame_done
);

    localparam int CNT_W = cnt_width(PRE_W, DATA_W, GAP_CYCLES);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    tx_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept;
    logic             shift;
    logic             msb;
    logic [PRE_W-1:0] pre_shifted;
    logic             out_d, out_valid_d, frame_done_d;

    piso_shift #(.DATA_W(DATA_W)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (shift),
        .din   (in_data),
        .msb   (msb)
    );

    assign in_ready = (state == ST_IDLE);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt + 1'b1;
        accept       = in_valid && (state == ST_IDLE);
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (accept) state_nxt = ST_PRE;
            end
            ST_PRE: begin
                if (cnt == PRE_LAST) begin
                    state_nxt = ST_DATA;
                    cnt_nxt   = '0;
                end
            end
            ST_DATA: begin
                if (cnt == DATA_LAST) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = '0;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // The register shifts on every edge that lands in DATA, so its MSB is always the bit to send.
        shift        = (state_nxt == ST_DATA);
        pre_shifted  = PREAMBLE << cnt_nxt;
        out_valid_d  = (state_nxt == ST_PRE) || (state_nxt == ST_DATA);
        frame_done_d = (state_nxt == ST_DATA) && (cnt_nxt == DATA_LAST);
        case (state_nxt)
            ST_PRE:  out_d = pre_shifted[PRE_W-1];
            ST_DATA: out_d = msb;
            default: out_d = IDLE_BIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            out        <= IDLE_BIT;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            out        <= out_d;
            out_valid  <= out_valid_d;
            frame_done <= frame_done_d;
        end
    end

endmodule
